// File: rtl/fb_mem_arbiter.sv
// PSRAM sequencer for the 8-bit framebuffer: scanout reads win over pixel writes,
// which are slotted into idle gaps. Every memory pin is driven straight from a flop.
module fb_mem_arbiter #(
    parameter int RD_CYCLES = 8,
    parameter int WR_CYCLES = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [14:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_overrun,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [14:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic [14:0] mem_adr,
    output logic [15:0] mem_db_out,
    output logic        mem_db_oe,
    input  logic [15:0] mem_db_in,
    output logic        mem_cs_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_lb_n,
    output logic        mem_ub_n
);

    localparam logic [7:0] RD_LOAD = 8'(RD_CYCLES - 1);
    localparam logic [7:0] WR_LOAD = 8'(WR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;

    logic        r_pend_valid;
    logic [14:0] r_pend_addr;

    logic        w_in_idle;
    logic        w_rd_start;
    logic        w_wr_start;
    logic        w_rd_done;
    logic        w_pend_load;
    logic [14:0] w_rd_start_addr;

    logic        w_cs_n_next;
    logic        w_oe_n_next;
    logic        w_we_n_next;
    logic        w_lb_n_next;
    logic        w_ub_n_next;
    logic        w_db_oe_next;

    logic        r_cs_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_lb_n;
    logic        r_ub_n;
    logic        r_db_oe;
    logic [14:0] r_adr;
    logic [15:0] r_db_out;
    logic [7:0]  r_rd_data;
    logic        r_rd_valid;
    logic        r_overrun;

    assign w_in_idle       = (r_state == S_IDLE);
    assign w_rd_start      = w_in_idle && (r_pend_valid || rd_req);
    assign w_rd_start_addr = r_pend_valid ? r_pend_addr : rd_addr;
    assign w_rd_done       = (r_state == S_RD) && (r_cnt == 8'd0);
    assign wr_ready        = w_in_idle && !r_pend_valid && !rd_req;
    assign w_wr_start      = wr_valid && wr_ready;
    // Park the request unless IDLE is launching it directly this very cycle
    assign w_pend_load     = rd_req && !(w_in_idle && !r_pend_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_rd_start) begin
                    w_state_next = S_RD;
                    w_cnt_next   = RD_LOAD;
                end else if (w_wr_start) begin
                    w_state_next = S_WR_SETUP;
                end
            end
            S_RD: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            S_WR_SETUP: begin
                w_state_next = S_WR_PULSE;
                w_cnt_next   = WR_LOAD;
            end
            S_WR_PULSE: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = S_WR_HOLD;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            S_WR_HOLD: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the upcoming state so the pins change with the state flop
    always_comb begin
        w_cs_n_next  = 1'b1;
        w_oe_n_next  = 1'b1;
        w_we_n_next  = 1'b1;
        w_lb_n_next  = 1'b1;
        w_ub_n_next  = 1'b1;
        w_db_oe_next = 1'b0;
        case (w_state_next)
            S_RD: begin
                w_cs_n_next = 1'b0;
                w_oe_n_next = 1'b0;
                w_lb_n_next = 1'b0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                w_cs_n_next  = 1'b0;
                w_lb_n_next  = 1'b0;
                w_db_oe_next = 1'b1;
            end
            S_WR_PULSE: begin
                w_cs_n_next  = 1'b0;
                w_we_n_next  = 1'b0;
                w_lb_n_next  = 1'b0;
                w_db_oe_next = 1'b1;
            end
            default: begin
                w_cs_n_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_db_oe <= 1'b0;
        end else begin
            r_cs_n  <= w_cs_n_next;
            r_oe_n  <= w_oe_n_next;
            r_we_n  <= w_we_n_next;
            r_lb_n  <= w_lb_n_next;
            r_ub_n  <= w_ub_n_next;
            r_db_oe <= w_db_oe_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adr        <= 15'd0;
            r_db_out     <= 16'd0;
            r_rd_data    <= 8'd0;
            r_rd_valid   <= 1'b0;
            r_overrun    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= 15'd0;
        end else begin
            r_rd_valid <= w_rd_done;
            if (w_rd_done) begin
                r_rd_data <= mem_db_in[7:0];
            end
            if (w_rd_start) begin
                r_adr <= w_rd_start_addr;
            end else if (w_wr_start) begin
                r_adr    <= wr_addr;
                r_db_out <= {8'h00, wr_data};
            end
            if (w_pend_load) begin
                r_pend_valid <= 1'b1;
                r_pend_addr  <= rd_addr;
            end else if (w_rd_start) begin
                r_pend_valid <= 1'b0;
            end
            // Newest request overwrites a still-waiting one; the older one is lost
            if (rd_req && r_pend_valid && !w_rd_start) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign rd_overrun = r_overrun;
    assign mem_adr    = r_adr;
    assign mem_db_out = r_db_out;
    assign mem_db_oe  = r_db_oe;
    assign mem_cs_n   = r_cs_n;
    assign mem_oe_n   = r_oe_n;
    assign mem_we_n   = r_we_n;
    assign mem_lb_n   = r_lb_n;
    assign mem_ub_n   = r_ub_n;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed timing cases plus randomized traffic against a
// PSRAM model and a request-ordered reference memory.
module tb_fb_mem_arbiter;
    localparam int RD_CYCLES = 8;
    localparam int WR_CYCLES = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_overrun;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic [14:0] mem_adr;
    logic [15:0] mem_db_out;
    logic        mem_db_oe;
    logic [15:0] mem_db_in;
    logic        mem_cs_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;
    logic [4:0]  strb;

    always #5 clk = ~clk;

    fb_mem_arbiter #(.RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_overrun(rd_overrun),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_adr(mem_adr), .mem_db_out(mem_db_out), .mem_db_oe(mem_db_oe), .mem_db_in(mem_db_in),
        .mem_cs_n(mem_cs_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n)
    );

    assign strb = {mem_cs_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    task automatic cyc_step;
        @(negedge clk);
        #1;
    endtask

    // PSRAM model and reference memory (updated in acceptance order)
    logic [7:0]  psram  [0:32767];
    logic [7:0]  refmem [0:32767];
    logic        mem_ready = 1'b0;
    logic        dir_db_en;
    logic [15:0] dir_db;
    logic [7:0]  upper_byte;
    logic        sb_en;
    logic        rd_done;

    assign mem_db_in = dir_db_en ? dir_db :
                       (!mem_cs_n && !mem_oe_n) ? {upper_byte, psram[mem_adr]} : 16'hBEEF;

    int          cyc   = 0;
    int          sb_wp = 0;
    int          sb_rp = 0;
    logic [14:0] sb_addr [0:63];
    logic [7:0]  sb_data [0:63];
    int          sb_t    [0:63];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 32768; i++) begin
                psram[i]  <= init_val(15'(i));
                refmem[i] <= init_val(15'(i));
            end
            mem_ready <= 1'b1;
        end else begin
            if (!mem_cs_n && !mem_we_n && mem_db_oe) psram[mem_adr] <= mem_db_out[7:0];
            if (!reset && wr_valid && wr_ready) refmem[wr_addr] <= wr_data;
        end
        if (sb_en && !reset && rd_req) begin
            sb_addr[sb_wp % 64] <= rd_addr;
            sb_data[sb_wp % 64] <= refmem[rd_addr];
            sb_t[sb_wp % 64]    <= cyc;
            sb_wp               <= sb_wp + 1;
            chk("wr_ready_low_on_rd_req", 32'(wr_ready), 0);
        end
    end

    always @(negedge clk) begin
        if (mem_ready) chk("bus_conflict", 32'(!mem_oe_n && mem_db_oe), 0);
        if (sb_en && rd_valid) begin
            chk("rd_valid_has_request", 32'(sb_rp != sb_wp), 1);
            if (sb_rp != sb_wp) begin
                chk("rand_rd_data", 32'(rd_data), 32'(sb_data[sb_rp % 64]));
                chk("rand_rd_latency", 32'((cyc - sb_t[sb_rp % 64] >= RD_CYCLES + 1) &&
                                           (cyc - sb_t[sb_rp % 64] <= WR_CYCLES + RD_CYCLES + 3)), 1);
                $display("[TB] rand read adr=0x%04h data=0x%02h lat=%0d",
                         sb_addr[sb_rp % 64], rd_data, cyc - sb_t[sb_rp % 64]);
                sb_rp <= sb_rp + 1;
            end
        end
    end

    int          n_act, first_act, last_act, n_valid, valid_k, acc_k;
    int          n_we, first_we, n_oe_drv, first_oe_drv, n_oe_low;
    logic [7:0]  got_data;
    int          vk [0:3];
    logic [7:0]  vd [0:3];

    initial begin
        reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        dir_db_en = 1'b0; dir_db = '0; upper_byte = 8'h00; sb_en = 1'b0; rd_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc_step;
        chk("rst_strobes", 32'(strb), 32'h1F);
        chk("rst_db_oe", 32'(mem_db_oe), 0);
        chk("rst_adr", 32'(mem_adr), 0);
        chk("rst_db_out", 32'(mem_db_out), 0);
        chk("rst_rd_outputs", 32'({rd_data, rd_valid, rd_overrun}), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);

        // Single read
        dir_db_en = 1'b1; dir_db = 16'h00A5;
        rd_req = 1'b1; rd_addr = 15'h1234;
        n_act = 0; first_act = 0; last_act = 0; n_valid = 0; valid_k = 0; got_data = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc_step;
            rd_req = 1'b0;
            if (!mem_cs_n && !mem_oe_n) begin
                n_act++;
                if (first_act == 0) first_act = k;
                last_act = k;
            end
            if (k == 1) begin
                chk("rd_adr", 32'(mem_adr), 32'h1234);
                chk("rd_lanes", 32'({mem_lb_n, mem_ub_n, mem_db_oe, mem_we_n}), 32'b0101);
            end
            if (rd_valid) begin n_valid++; valid_k = k; got_data = rd_data; end
        end
        chk("rd_strobe_cycles", 32'(n_act), 8);
        chk("rd_strobe_first", 32'(first_act), 1);
        chk("rd_strobe_last", 32'(last_act), 8);
        chk("rd_valid_count", 32'(n_valid), 1);
        chk("rd_valid_time", 32'(valid_k), 9);
        chk("rd_data", 32'(got_data), 32'hA5);
        $display("[TB] read adr=0x1234 data=0x%02h valid_at=+%0d", got_data, valid_k);
        dir_db_en = 1'b0;

        // Single write
        wr_valid = 1'b1; wr_addr = 15'h0042; wr_data = 8'h3C;
        #1;
        chk("wr_ready_accept", 32'(wr_ready), 1);
        n_we = 0; first_we = 0; n_oe_drv = 0; first_oe_drv = 0; n_oe_low = 0;
        for (int k = 1; k <= 14; k++) begin
            cyc_step;
            wr_valid = 1'b0;
            if (!mem_we_n) begin n_we++; if (first_we == 0) first_we = k; end
            if (mem_db_oe) begin n_oe_drv++; if (first_oe_drv == 0) first_oe_drv = k; end
            if (!mem_oe_n) n_oe_low++;
            if (k == 2) chk("wr_db_out", 32'(mem_db_out), 32'h003C);
            if (k == 2) chk("wr_adr", 32'(mem_adr), 32'h0042);
            if (k == 5) chk("wr_ready_busy", 32'(wr_ready), 0);
            if (k == 10) chk("wr_ready_idle_again", 32'(wr_ready), 1);
        end
        chk("wr_we_cycles", 32'(n_we), 7);
        chk("wr_we_first", 32'(first_we), 2);
        chk("wr_db_oe_cycles", 32'(n_oe_drv), 9);
        chk("wr_db_oe_first", 32'(first_oe_drv), 1);
        chk("wr_oe_n_high", 32'(n_oe_low), 0);
        $display("[TB] write adr=0x0042 data=0x3c we_cycles=%0d", n_we);

        // Read and write in the same idle cycle
        rd_req = 1'b1; rd_addr = 15'h0500; wr_valid = 1'b1; wr_addr = 15'h0010; wr_data = 8'h77;
        #1;
        chk("contend_wr_ready", 32'(wr_ready), 0);
        acc_k = 0; valid_k = 0; got_data = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc_step;
            rd_req = 1'b0;
            #1;
            if (rd_valid) begin valid_k = k; got_data = rd_data; end
            if (acc_k != 0) wr_valid = 1'b0;
            else if (wr_valid && wr_ready) acc_k = k;
        end
        chk("contend_rd_valid_time", 32'(valid_k), 9);
        chk("contend_rd_data", 32'(got_data), 32'(init_val(15'h0500)));
        chk("contend_wr_accept_time", 32'(acc_k), 9);
        $display("[TB] contend read=0x%02h at +%0d write accepted at +%0d", got_data, valid_k, acc_k);

        // Read request one cycle after a write is accepted
        wr_valid = 1'b1; wr_addr = 15'h0042; wr_data = 8'hC3;
        #1;
        chk("rdw_wr_ready", 32'(wr_ready), 1);
        cyc_step;
        wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 15'h0042;
        valid_k = 0; got_data = 0;
        for (int k = 2; k <= 25; k++) begin
            cyc_step;
            rd_req = 1'b0;
            if (rd_valid) begin valid_k = k; got_data = rd_data; end
        end
        chk("rdw_valid_time", 32'(valid_k), 19);
        chk("rdw_data_after_write", 32'(got_data), 32'hC3);
        chk("rdw_no_overrun", 32'(rd_overrun), 0);
        $display("[TB] read-during-write data=0x%02h valid_at=+%0d", got_data, valid_k);

        // Three back-to-back requests around the end of a write
        wr_valid = 1'b1; wr_addr = 15'h0043; wr_data = 8'h11;
        #1;
        chk("ovr_wr_ready", 32'(wr_ready), 1);
        n_valid = 0;
        for (int k = 1; k <= 35; k++) begin
            cyc_step;
            wr_valid = 1'b0;
            if (rd_valid) begin
                if (n_valid < 4) begin vk[n_valid] = k; vd[n_valid] = rd_data; end
                n_valid++;
            end
            rd_req  = (k >= 9) && (k <= 11);
            rd_addr = (k == 9) ? 15'h0100 : (k == 10) ? 15'h0200 : 15'h0300;
        end
        chk("ovr_flag", 32'(rd_overrun), 1);
        chk("ovr_valid_count", 32'(n_valid), 2);
        if (n_valid >= 2) begin
            chk("ovr_first_time", 32'(vk[0]), 19);
            chk("ovr_first_data", 32'(vd[0]), 32'(init_val(15'h0100)));
            chk("ovr_second_time", 32'(vk[1]), 28);
            chk("ovr_second_data", 32'(vd[1]), 32'(init_val(15'h0300)));
        end
        $display("[TB] overrun reads=%0d overrun=%0b", n_valid, rd_overrun);

        // Reset during the write pulse
        wr_valid = 1'b1; wr_addr = 15'h0044; wr_data = 8'h22;
        for (int k = 1; k <= 4; k++) begin
            cyc_step;
            wr_valid = 1'b0;
        end
        chk("pre_rst_we_low", 32'(mem_we_n), 0);
        reset = 1'b1; wr_valid = 1'b1; wr_addr = 15'h0045; wr_data = 8'h33;
        cyc_step;
        reset = 1'b0;
        #1;
        chk("rst_wr_strobes", 32'(strb), 32'h1F);
        chk("rst_wr_db_oe", 32'(mem_db_oe), 0);
        chk("rst_wr_overrun_clr", 32'(rd_overrun), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        cyc_step;
        wr_valid = 1'b0;
        repeat (12) cyc_step;
        $display("[TB] reset mid-write strobes=0x%02h", strb);

        // Reset during a read suppresses rd_valid
        rd_req = 1'b1; rd_addr = 15'h0600;
        cyc_step;
        rd_req = 1'b0;
        cyc_step;
        cyc_step;
        reset = 1'b1;
        cyc_step;
        reset = 1'b0;
        chk("rst_rd_strobes", 32'(strb), 32'h1F);
        n_valid = 0;
        if (rd_valid) n_valid++;
        for (int k = 5; k <= 15; k++) begin
            cyc_step;
            if (rd_valid) n_valid++;
        end
        chk("rst_rd_no_valid", 32'(n_valid), 0);
        $display("[TB] reset mid-read valid_pulses=%0d", n_valid);

        // Randomized traffic
        sb_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int gap;
                    gap = int'($urandom_range(RD_CYCLES + 1, RD_CYCLES + 5));
                    repeat (gap - 1) cyc_step;
                    rd_req = 1'b1;
                    rd_addr = 15'($urandom_range(0, 63));
                    upper_byte = 8'($urandom);
                    cyc_step;
                    rd_req = 1'b0;
                end
                rd_done = 1'b1;
            end
            begin
                logic acc_pend;
                acc_pend = 1'b0;
                while (!rd_done) begin
                    cyc_step;
                    if (acc_pend) wr_valid = 1'b0;
                    if (!wr_valid && $urandom_range(0, 2) == 0) begin
                        wr_valid = 1'b1;
                        wr_addr  = 15'($urandom_range(0, 63));
                        wr_data  = 8'($urandom);
                    end
                    #1;
                    acc_pend = wr_valid && wr_ready;
                end
                cyc_step;
                wr_valid = 1'b0;
            end
        join
        for (int i = 0; i < 40 && sb_rp != sb_wp; i++) cyc_step;
        chk("rand_drained", 32'(sb_rp == sb_wp), 1);
        chk("rand_read_count", 32'(sb_rp), 40);
        chk("rand_no_overrun", 32'(rd_overrun), 0);
        sb_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
